// File: rtl/alu_sequencer.sv
// Issue-side controller for the a*b + c*d + e fixed-point ALU: sequences operand
// captures per instruction and writes the settled result back to the register file.
module alu_sequencer #(
  parameter int BUS_WIDTH     = 8,
  parameter int REG_ADDR_W    = 3,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  output logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [BUS_WIDTH-1:0]  alu_imm,
  output logic [4:0]            alu_reg_en,
  output logic                  alu_f_add,
  output logic                  alu_f_load,
  input  logic [BUS_WIDTH-1:0]  alu_result,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [BUS_WIDTH-1:0]  wb_data,
  output logic                  busy,
  output logic                  illegal_op
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDSW = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_LIN  = 3'b100;
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_I0, S_I1, S_I2, S_SETTLE, S_WB
  } state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_op, r_rd, r_ra, r_rb, r_rc;
  logic [7:0]  r_k0, r_k1;
  logic [3:0]  r_cnt;
  logic        w_accept;
  logic        w_reserved;
  logic        w_unused_rsvd;

  assign w_unused_rsvd = instr[16];
  assign w_accept      = instr_valid && (r_state == S_IDLE);
  assign w_reserved    = !(instr[31:29] inside {OP_NOP, OP_LDSW, OP_MOV, OP_LIN});
  assign illegal_op    = w_accept && w_reserved && !rst;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_k0    <= '0;
      r_k1    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= instr[31:29];
        r_rd <= instr[28:26];
        r_ra <= instr[25:23];
        r_rb <= instr[22:20];
        r_rc <= instr[19:17];
        r_k0 <= instr[15:8];
        r_k1 <= instr[7:0];
      end
      // Counter preloads on the I2->SETTLE edge so SETTLE lasts exactly SETTLE_CYCLES.
      if (r_state == S_I2)
        r_cnt <= SETTLE_LOAD;
      else if (r_state == S_SETTLE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    alu_imm     = '0;
    alu_reg_en  = 5'b00000;
    alu_f_add   = 1'b0;
    alu_f_load  = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (instr[31:29])
            OP_LDSW, OP_MOV: w_next = S_I2;
            OP_LIN:          w_next = S_I0;
            default:         w_next = S_IDLE;
          endcase
        end
      end
      S_I0: begin
        rd_addr_a  = REG_ADDR_W'(r_ra);
        alu_f_add  = 1'b1;
        alu_imm    = BUS_WIDTH'(r_k0);
        alu_reg_en = 5'b00011;
        w_next     = S_I1;
      end
      S_I1: begin
        rd_addr_b  = REG_ADDR_W'(r_rb);
        alu_f_add  = 1'b1;
        alu_imm    = BUS_WIDTH'(r_k1);
        alu_reg_en = 5'b01100;
        w_next     = S_I2;
      end
      S_I2: begin
        // MOV/LDSW zero the B and D coefficients so leftover products drop out of the sum.
        case (r_op)
          OP_LIN: begin
            rd_addr_a  = REG_ADDR_W'(r_rc);
            alu_f_load = 1'b1;
            alu_reg_en = 5'b10000;
          end
          OP_MOV: begin
            rd_addr_a  = REG_ADDR_W'(r_ra);
            alu_f_load = 1'b1;
            alu_reg_en = 5'b11010;
          end
          default: alu_reg_en = 5'b11010;
        endcase
        w_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_WB;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_next = S_WB;
      end
      S_WB: begin
        wb_en   = 1'b1;
        wb_addr = REG_ADDR_W'(r_rd);
        wb_data = alu_result;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: two sequencers (no settle / 2 settle cycles) sharing one instruction stream;
// the first drives a behavioural ALU + register file so write-back data can be checked.
module tb_alu_sequencer;

  localparam logic [2:0] NOP = 3'b000, LDSW = 3'b001, MOV = 3'b010, LIN = 3'b100;
  localparam logic [7:0] RF_INIT [8] = '{8'h00, 8'h11, 8'd10, 8'd3, 8'd20, 8'h77, 8'h80, 8'hFE};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_valid;
  logic [31:0] instr;
  logic [7:0]  sw;

  logic       rdy0, fadd0, fload0, wben0, busy0, ill0;
  logic [2:0] ra0, rb0, wba0;
  logic [7:0] imm0, res0, wbd0;
  logic [4:0] en0;
  logic       rdy2, fadd2, fload2, wben2, busy2, ill2;
  logic [2:0] ra2, rb2, wba2;
  logic [7:0] imm2, wbd2;
  logic [4:0] en2;
  logic [7:0] res2;
  assign res2 = 8'hC3;

  alu_sequencer #(.BUS_WIDTH(8), .REG_ADDR_W(3), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(rdy0),
    .rd_addr_a(ra0), .rd_addr_b(rb0), .alu_imm(imm0), .alu_reg_en(en0), .alu_f_add(fadd0),
    .alu_f_load(fload0), .alu_result(res0), .wb_en(wben0), .wb_addr(wba0), .wb_data(wbd0),
    .busy(busy0), .illegal_op(ill0));

  alu_sequencer #(.BUS_WIDTH(8), .REG_ADDR_W(3), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(rdy2),
    .rd_addr_a(ra2), .rd_addr_b(rb2), .alu_imm(imm2), .alu_reg_en(en2), .alu_f_add(fadd2),
    .alu_f_load(fload2), .alu_result(res2), .wb_en(wben2), .wb_addr(wba2), .wb_data(wbd2),
    .busy(busy2), .illegal_op(ill2));

  // Environment: register file and ALU operand registers around dut0.
  logic [7:0] rf [8];
  logic [7:0] ma, mb, mc, md, me;

  function automatic logic [7:0] alu_eval(input logic [7:0] a, b, c, d, e);
    int s;
    s = (int'(a) * int'(b)) / 128 + (int'(c) * int'(d)) / 128 + int'(e);
    return s[7:0];
  endfunction

  assign res0 = alu_eval(ma, mb, mc, md, me);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= RF_INIT[i];
      ma <= 8'h55; mb <= 8'h66; mc <= 8'h77; md <= 8'h44; me <= 8'h12;
    end else begin
      if (wben0) rf[wba0] <= wbd0;
      if (en0[0]) ma <= rf[ra0];
      if (en0[1]) mb <= fadd0 ? imm0 : 8'h00;
      if (en0[2]) mc <= rf[rb0];
      if (en0[3]) md <= fadd0 ? imm0 : 8'h00;
      if (en0[4]) me <= fadd0 ? imm0 : (fload0 ? rf[ra0] : sw);
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, rd, ra, rb, rc, input logic rsvd,
                                     input logic [7:0] k0, k1);
    return {op, rd, ra, rb, rc, rsvd, k0, k1};
  endfunction

  // Per-cycle captures of one instruction, cycles 1..9 after the accept cycle.
  logic [4:0] c_en0 [1:9];
  logic [4:0] c_en2 [1:9];
  logic       c_rdy0 [1:9];
  logic       c_rdy2 [1:9];
  logic       c_ill0, c_rdy00;
  logic [7:0] c_wbd0, c_wbd2;
  logic [2:0] c_wba0;
  int         wbc0, wbc2, nwb0, nwb2, illx;

  task automatic issue(input logic [31:0] ins, input logic [7:0] swv);
    @(negedge clk);
    instr = ins; sw = swv; instr_valid = 1'b1;
    #1;
    c_ill0 = ill0; c_rdy00 = rdy0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wbc0 = -1; wbc2 = -1; nwb0 = 0; nwb2 = 0; illx = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      c_en0[k] = en0; c_rdy0[k] = rdy0; c_en2[k] = en2; c_rdy2[k] = rdy2;
      if (wben0) begin
        nwb0++;
        if (wbc0 < 0) begin wbc0 = k; c_wbd0 = wbd0; c_wba0 = wba0; end
      end
      if (wben2) begin
        nwb2++;
        if (wbc2 < 0) begin wbc2 = k; c_wbd2 = wbd2; end
      end
      if (ill0 || ill2) illx++;
    end
  endtask

  typedef struct {
    logic [2:0] op, rd, ra, rb, rc;
    logic       rsvd;
    logic [7:0] k0, k1, sw;
    int         wbc;
    logic [2:0] wba;
    logic [7:0] wbd;
    logic       ill;
    logic [4:0] en1, en2, en3;
    logic       rdy1;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] ref_rf [8];

  initial begin
    int anyr, ewbc;
    logic [2:0] op, rd, ra, rb, rc;
    logic [7:0] k0, k1, swr, exp_d;
    logic       res_op;

    // LIN ra=r2(10) rb=r4(20) rc=r3(3): 10*0.5 + 20*0.25 + 3 = 13
    tbl[0] = '{LIN,  3'd1, 3'd2, 3'd4, 3'd3, 1'b0, 8'h40, 8'h20, 8'h00, 4, 3'd1, 8'h0D, 1'b0, 5'b00011, 5'b01100, 5'b10000, 1'b0};
    // MOV with nonzero products still held in the ALU
    tbl[1] = '{MOV,  3'd5, 3'd7, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 2, 3'd5, 8'hFE, 1'b0, 5'b11010, 5'b00000, 5'b00000, 1'b0};
    tbl[2] = '{LDSW, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h5A, 2, 3'd3, 8'h5A, 1'b0, 5'b11010, 5'b00000, 5'b00000, 1'b0};
    tbl[3] = '{NOP,  3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 8'h11, 8'h22, 8'h33, -1, 3'd0, 8'h00, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1};
    tbl[4] = '{3'b111, 3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 8'h11, 8'h22, 8'h33, -1, 3'd0, 8'h00, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1};
    // 0x5A*1 + 0x0D*1 + 0xFE = 357 -> 0x65 (wraps); rsvd bit set
    tbl[5] = '{LIN,  3'd0, 3'd3, 3'd1, 3'd5, 1'b1, 8'h80, 8'h80, 8'h00, 4, 3'd0, 8'h65, 1'b0, 5'b00011, 5'b01100, 5'b10000, 1'b0};
    tbl[6] = '{MOV,  3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 2, 3'd6, 8'h65, 1'b0, 5'b11010, 5'b00000, 5'b00000, 1'b0};
    tbl[7] = '{3'b011, 3'd4, 3'd2, 3'd2, 3'd2, 1'b0, 8'hFF, 8'hFF, 8'hFF, -1, 3'd0, 8'h00, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1};
    tbl[8] = '{LDSW, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 2, 3'd7, 8'h00, 1'b0, 5'b11010, 5'b00000, 5'b00000, 1'b0};
    // 101*255/128 = 201, + 0 + 101 = 302 -> 0x2E
    tbl[9] = '{LIN,  3'd2, 3'd6, 3'd7, 3'd0, 1'b0, 8'hFF, 8'hFF, 8'h00, 4, 3'd2, 8'h2E, 1'b0, 5'b00011, 5'b01100, 5'b10000, 1'b0};

    rst = 1'b1; instr_valid = 1'b0; instr = '0; sw = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_reg_en", en0, 0);
    chk("rst_wb_en", wben0, 0);
    chk("rst_imm", imm0, 0);
    chk("rst_addr_a", ra0, 0);
    chk("rst_illegal", ill0, 0);
    chk("rst_wb_data", wbd0, 0);

    for (int i = 0; i < 10; i++) begin
      issue(mk(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].rsvd, tbl[i].k0, tbl[i].k1), tbl[i].sw);
      chk($sformatf("v%0d_ready0", i), c_rdy00, 1);
      chk($sformatf("v%0d_illegal", i), c_ill0, tbl[i].ill);
      chk($sformatf("v%0d_illegal_len", i), illx, 0);
      chk($sformatf("v%0d_wb_cycle", i), wbc0, tbl[i].wbc);
      chk($sformatf("v%0d_wb_count", i), nwb0, (tbl[i].wbc < 0) ? 0 : 1);
      chk($sformatf("v%0d_wb_cycle_s2", i), wbc2, (tbl[i].wbc < 0) ? -1 : tbl[i].wbc + 2);
      chk($sformatf("v%0d_en_c1", i), c_en0[1], tbl[i].en1);
      chk($sformatf("v%0d_en_c2", i), c_en0[2], tbl[i].en2);
      chk($sformatf("v%0d_en_c3", i), c_en0[3], tbl[i].en3);
      chk($sformatf("v%0d_ready_c1", i), c_rdy0[1], tbl[i].rdy1);
      if (tbl[i].wbc >= 0) begin
        chk($sformatf("v%0d_wb_addr", i), c_wba0, tbl[i].wba);
        chk($sformatf("v%0d_wb_data", i), c_wbd0, tbl[i].wbd);
      end
    end

    // Reset while in I1 of a LIN: must abort with no write-back.
    @(negedge clk);
    instr = mk(LIN, 3'd1, 3'd2, 3'd4, 3'd3, 1'b0, 8'h40, 8'h20); instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_I1", en0, 5'b01100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", rdy0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_reg_en", en0, 0);
    chk("abort_addr_b", rb0, 0);
    chk("abort_imm", imm0, 0);
    chk("abort_fadd", fadd0, 0);
    chk("abort_ready_s2", rdy2, 1);
    nwb0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wben0 || wben2) nwb0++;
    end
    chk("abort_no_wb", nwb0, 0);

    // SETTLE_CYCLES=2 LIN timing.
    issue(mk(LIN, 3'd4, 3'd2, 3'd4, 3'd3, 1'b0, 8'h40, 8'h20), 8'h00);
    chk("s2_wb_cycle", wbc2, 6);
    chk("s2_wb_data", c_wbd2, 8'hC3);
    chk("s2_en_c3", c_en2[3], 5'b10000);
    chk("s2_en_c4", c_en2[4], 0);
    chk("s2_en_c5", c_en2[5], 0);
    anyr = 0;
    for (int k = 1; k <= 6; k++) if (c_rdy2[k]) anyr++;
    chk("s2_ready_low_c1_6", anyr, 0);
    chk("s2_ready_c7", c_rdy2[7], 1);
    chk("s0_wb_data_after_rst", c_wbd0, 8'h0D);

    // Random stream against a register-level reference model.
    for (int i = 0; i < 8; i++) ref_rf[i] = RF_INIT[i];
    ref_rf[4] = 8'h0D;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = LIN;
        3, 4:    op = MOV;
        5, 6:    op = LDSW;
        default: op = 3'($urandom_range(0, 7));
      endcase
      rd = 3'($urandom_range(0, 7)); ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7)); rc = 3'($urandom_range(0, 7));
      k0 = 8'($urandom_range(0, 255)); k1 = 8'($urandom_range(0, 255));
      swr = 8'($urandom_range(0, 255));
      res_op = !(op inside {NOP, LDSW, MOV, LIN});
      ewbc = (op == LIN) ? 4 : (op == LDSW || op == MOV) ? 2 : -1;
      case (op)
        LDSW:    exp_d = swr;
        MOV:     exp_d = ref_rf[ra];
        LIN:     exp_d = 8'((int'(ref_rf[ra]) * int'(k0)) / 128 + (int'(ref_rf[rb]) * int'(k1)) / 128 + int'(ref_rf[rc]));
        default: exp_d = 8'h00;
      endcase
      issue(mk(op, rd, ra, rb, rc, 1'($urandom_range(0, 1)), k0, k1), swr);
      chk($sformatf("r%0d_illegal", n), c_ill0, res_op);
      chk($sformatf("r%0d_wb_cycle", n), wbc0, ewbc);
      chk($sformatf("r%0d_wb_cycle_s2", n), wbc2, (ewbc < 0) ? -1 : ewbc + 2);
      if (ewbc >= 0) begin
        chk($sformatf("r%0d_wb_addr", n), c_wba0, rd);
        chk($sformatf("r%0d_wb_data", n), c_wbd0, exp_d);
        ref_rf[rd] = exp_d;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
